// File: rtl/sonar_frame_formatter_pkg.sv
// Shared constants and FSM encoding for the sonar frame formatter.
package sonar_frame_formatter_pkg;

    localparam logic [6:0] CHAR_SEP         = 7'h2C;
    localparam logic [6:0] CHAR_END         = 7'h23;
    localparam logic [6:0] CHAR_ERR         = 7'h3F;
    localparam logic [2:0] ASCII_DIGIT_BASE = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3
    } state_t;

endpackage

// File: rtl/sonar_frame_formatter_bcd_to_ascii.sv
// Converts one BCD nibble to its ASCII digit; non-BCD nibbles map to '?' with err set.
module bcd_to_ascii
    import sonar_frame_formatter_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] ascii,
    output logic       err
);

    always_comb begin
        err   = (nibble > 4'd9);
        ascii = err ? CHAR_ERR : {ASCII_DIGIT_BASE, nibble};
    end

endmodule

// File: rtl/sonar_frame_formatter.sv
// Snapshots BCD angle/distance and sends "<angle>,<distance>#" one character per
// start/ready handshake; also keeps a registered proximity alert.
module sonar_frame_formatter
    import sonar_frame_formatter_pkg::*;
#(
    parameter int unsigned                 ANG_DIGITS  = 3,
    parameter int unsigned                 DIST_DIGITS = 3,
    parameter logic [4*DIST_DIGITS-1:0]    ALERT_BCD   = 12'h010
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [4*ANG_DIGITS-1:0]    angle_bcd,
    input  logic [4*DIST_DIGITS-1:0]   dist_bcd,
    input  logic                       dist_valid,
    input  logic                       detect_en,
    input  logic                       tx_ready,
    output logic                       tx_start,
    output logic [6:0]                 tx_data,
    output logic                       busy,
    output logic                       done,
    output logic                       alert,
    output logic                       bcd_error,
    output logic [2:0]                 db_state
);

    localparam int unsigned FRAME_LEN = ANG_DIGITS + DIST_DIGITS + 2;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam int unsigned NIB_CNT   = ANG_DIGITS + DIST_DIGITS;
    localparam logic [IDX_W-1:0] SEP_IDX  = IDX_W'(ANG_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q;
    logic [4*ANG_DIGITS-1:0]    ang_q;
    logic [4*DIST_DIGITS-1:0]   dist_q;
    logic                       bcd_error_q;
    logic                       alert_q;

    logic [4*NIB_CNT-1:0]       nibs;
    logic [3:0]                 sel_nib;
    logic                       is_digit;
    int unsigned                pos;
    logic [6:0]                 digit_char;
    logic                       nib_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_start = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_SEND;
            ST_SEND: begin
                tx_start = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: if (tx_ready) state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_SEND;
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            ang_q       <= '0;
            dist_q      <= '0;
            bcd_error_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                ang_q       <= angle_bcd;
                dist_q      <= dist_bcd;
                idx_q       <= '0;
                bcd_error_q <= 1'b0;
            end else begin
                if (state_q == ST_WAIT && tx_ready && idx_q != LAST_IDX) begin
                    idx_q <= idx_q + 1'b1;
                end
                if (state_q == ST_SEND && is_digit && nib_err) begin
                    bcd_error_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alert_q <= 1'b0;
        end else if (dist_valid) begin
            alert_q <= detect_en && (dist_bcd < ALERT_BCD);
        end
    end

    // Angle and distance nibbles are concatenated so the separator slot is skipped
    // by shifting idx down by one for distance digits.
    assign nibs = {ang_q, dist_q};

    always_comb begin
        is_digit = 1'b1;
        pos      = 0;
        sel_nib  = '0;
        if (idx_q < SEP_IDX) begin
            pos = 32'(idx_q);
        end else if (idx_q == SEP_IDX || idx_q == LAST_IDX) begin
            is_digit = 1'b0;
        end else begin
            pos = 32'(idx_q) - 1;
        end
        for (int unsigned i = 0; i < NIB_CNT; i++) begin
            if (i == pos) sel_nib = nibs[4*(NIB_CNT-1-i) +: 4];
        end
    end

    bcd_to_ascii u_bcd_to_ascii (
        .nibble (sel_nib),
        .ascii  (digit_char),
        .err    (nib_err)
    );

    always_comb begin
        if (is_digit)              tx_data = digit_char;
        else if (idx_q == SEP_IDX) tx_data = CHAR_SEP;
        else                       tx_data = CHAR_END;
    end

    assign busy      = (state_q != ST_IDLE);
    assign alert     = alert_q;
    assign bcd_error = bcd_error_q;
    assign db_state  = state_q;

endmodule

// File: doc/sonar_frame_formatter.md
# sonar_frame_formatter

Parametrised ASCII frame builder and serial-transmit sequencer for the sonar datapath. It snapshots a BCD angle and a BCD distance and emits the frame "<angle digits>,<distance digits>#" one character at a time. Each character goes to the 7O1 serial transmitter through a start/ready handshake. It also keeps a registered proximity alert, with the threshold set by a parameter. Digit counts are generic, replacing the fixed 3+3-digit mux/counter chain of the previous datapath.

## Interface
- ANG_DIGITS, 3: number of angle BCD digits (1..4).
- DIST_DIGITS, 3: number of distance BCD digits (1..4).
- ALERT_BCD, 12'h010: packed-BCD proximity threshold, width 4*DIST_DIGITS.
- clock  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request one frame; sampled only in IDLE.
- angle_bcd  in  4*ANG_DIGITS  angle, packed BCD, most-significant digit in the top nibble.
- dist_bcd  in  4*DIST_DIGITS  distance, packed BCD, most-significant digit in the top nibble.
- dist_valid  in  1  one-cycle pulse; dist_bcd is valid in that cycle.
- detect_en  in  1  enables the proximity alert.
- tx_ready  in  1  one-cycle pulse from the transmitter: the current character is finished.
- tx_start  out  1  one-cycle pulse: transmit tx_data.
- tx_data  out  7  ASCII character.
- busy  out  1  high from frame accept until done.
- done  out  1  one-cycle pulse after the last character's tx_ready.
- alert  out  1  registered proximity alert.
- bcd_error  out  1  sticky: a non-BCD nibble was sent; cleared on start.
- db_state  out  3  FSM state encoding.

## Operation
- Frame length L = ANG_DIGITS + DIST_DIGITS + 2. Character order:
  - angle digits, MSD first;
  - ',' (7'h2C);
  - distance digits, MSD first;
  - '#' (7'h23).
- Digit d encodes as {3'b011, d}. A nibble greater than 9 encodes as '?' (7'h3F) and sets bcd_error.
- FSM states: IDLE, SEND, WAIT, DONE.
  - IDLE: when start=1, capture angle_bcd and dist_bcd into snapshot registers, set idx=0, clear bcd_error, and go to SEND.
  - SEND: tx_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: on tx_ready, if idx==L-1 go to DONE; otherwise idx++ and go to SEND. With no tx_ready, stay in WAIT.
  - DONE: done=1 for one cycle, then go to IDLE.
- busy = (state != IDLE).
- start is ignored in SEND, WAIT and DONE; it is not queued. tx_ready is ignored outside WAIT.
- tx_data = char(snapshot, idx), combinational from registers only. It stays stable from the tx_start cycle through the matching tx_ready.
- Input changes after capture do not affect the frame in progress.
- Alert: on each dist_valid, alert <= detect_en && (dist_bcd < ALERT_BCD). Packed-BCD unsigned comparison equals numeric comparison.
  - alert holds between dist_valid pulses.
  - Clearing detect_en takes effect at the next dist_valid, not immediately.
- alert updates independently of the frame FSM. dist_valid during a frame is legal.

## Timing
- Reset values: state IDLE, idx 0, snapshots 0, tx_start 0, done 0, busy 0, alert 0, bcd_error 0. tx_data = 7'h30 (char 0 of a zero snapshot).
- start sampled at edge k: tx_start is high in cycle k+1 and busy rises at k+1.
- tx_ready at edge j (idx < L-1): the next tx_start is in cycle j+1.
- The last tx_ready at edge j: done is high in cycle j+1; busy falls and a new start is accepted in cycle j+2.
- Minimum frame duration is 2L+1 cycles after accept, when tx_ready returns one cycle after each tx_start.
- tx_ready arriving in the same cycle as tx_start (SEND) is ignored. The transmitter must not respond in zero cycles.
- Asynchronous reset mid-frame: outputs return to reset values immediately and the partial frame is abandoned. The next accepted start restarts at idx 0.
- alert latency: 1 cycle after dist_valid.

## Structure
- Shared package holds the ASCII constants: CHAR_SEP=7'h2C, CHAR_END=7'h23, CHAR_ERR=7'h3F, ASCII_DIGIT_BASE=3'b011. It also holds the FSM state encoding.
- idx width is $clog2(L).
- One sub-module: bcd_to_ascii (4-bit nibble in, 7-bit char out, err flag out), instantiated once on the selected nibble.

## Test plan
- Defaults: angle 12'h045, dist 12'h123, tx_ready 3 cycles after each tx_start -> tx_data sequence 30,34,35,2C,31,32,33,23 (hex); 8 tx_start pulses; one done pulse; bcd_error=0.
- Alert, detect_en=1: dist 12'h009 with dist_valid -> alert=1 next cycle. Dist 12'h010 -> alert=0. Dist 12'h005 with detect_en=0 -> alert=0.
- Snapshot and busy: change angle/dist and pulse start during WAIT of char 2 -> transmitted frame unchanged, no second frame, busy stays high.
- Reset mid-frame: assert reset in WAIT of char 4 -> tx_start=0, busy=0 at once. Then start with angle 12'h180, dist 12'h200 -> a full 8-character frame from '1'.
- ANG_DIGITS=2, DIST_DIGITS=4: angle 8'h90, dist 16'h0250 -> 39,30,2C,30,32,35,30,23 (hex).
- Invalid BCD: dist 12'h1A3 -> 6th character 3F, bcd_error=1 until the next start.
